// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit combinational ALU between two requesters.
// A request is arbitrated in IDLE, its operands are registered onto the ALU
// for EXEC_CYCLES cycles, the result is captured, and a single response is
// returned tagged with the id of the port that issued it.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1,    // ALU settle time, 1..15
  parameter bit          RR_ENABLE   = 1'b1  // 1 = round-robin, 0 = port 0 priority
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_op,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_op,

  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,

  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic       rsp_id,

  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;

  // Counter value of the final EXEC cycle, where the ALU output is captured.
  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic [3:0] exec_cnt;
  logic       last_grant;  // port granted most recently; drives round-robin
  logic       inflight_id; // port that owns the operation currently on the ALU

  logic       grant;       // port that would win arbitration this cycle
  logic       accept;      // a request is taken this cycle
  logic [7:0] grant_a;
  logic [7:0] grant_b;
  logic [2:0] grant_op;
  logic       op_err;

  // Pick the winning port from the current valids and the round-robin pointer.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = RR_ENABLE ? ~last_grant : 1'b0;
    end else begin
      grant = req1_valid;
    end
  end

  // Ready is offered only in IDLE, only to the winner, and never during reset.
  assign accept     = !rst && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept &&  grant;

  assign grant_a  = grant ? req1_a  : req0_a;
  assign grant_b  = grant ? req1_b  : req0_b;
  assign grant_op = grant ? req1_op : req0_op;

  // Divide by zero and the unused selects 101..111 bypass the ALU result.
  assign op_err = ((alu_sel == OP_DIV) && (alu_b == 8'h00)) || (alu_sel > OP_SHR);

  assign busy = (state != IDLE);

  // Transaction FSM: accept -> hold operands on ALU -> capture -> respond.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state       <= IDLE;
      exec_cnt    <= 4'd0;
      last_grant  <= 1'b1;
      inflight_id <= 1'b0;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_sel     <= 3'b000;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
      rsp_carry   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_id      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a       <= grant_a;
            alu_b       <= grant_b;
            alu_sel     <= grant_op;
            inflight_id <= grant;
            last_grant  <= grant;
            exec_cnt    <= 4'd0;
            state       <= EXEC;
          end
        end

        EXEC: begin
          if (exec_cnt == LAST_CNT) begin
            rsp_valid <= 1'b1;
            rsp_id    <= inflight_id;
            rsp_err   <= op_err;
            rsp_data  <= op_err ? 8'h00 : alu_result;
            rsp_carry <= !op_err && (alu_sel == OP_ADD) && alu_carry;
            state     <= RESP;
          end else begin
            exec_cnt <= exec_cnt + 4'd1;
          end
        end

        RESP: begin
          // rsp_* stay frozen until the consumer takes the response.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. Two instances share the clock:
// dut_a (EXEC_CYCLES=1, round-robin) and dut_b (EXEC_CYCLES=4, fixed priority).
// Each has a behavioural ALU attached. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_alu_arbiter;

  localparam int A_EXEC = 1;
  localparam int B_EXEC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A signals ----------------
  logic       a_rst;
  logic       a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
  logic [7:0] a_req0_a, a_req0_b, a_req1_a, a_req1_b;
  logic [2:0] a_req0_op, a_req1_op;
  logic [7:0] a_alu_a, a_alu_b, a_alu_result;
  logic [2:0] a_alu_sel;
  logic       a_alu_carry;
  logic       a_rsp_valid, a_rsp_ready, a_rsp_carry, a_rsp_err, a_rsp_id, a_busy;
  logic [7:0] a_rsp_data;

  // ---------------- instance B signals ----------------
  logic       b_rst;
  logic       b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [7:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
  logic [2:0] b_req0_op, b_req1_op;
  logic [7:0] b_alu_a, b_alu_b, b_alu_result;
  logic [2:0] b_alu_sel;
  logic       b_alu_carry;
  logic       b_rsp_valid, b_rsp_ready, b_rsp_carry, b_rsp_err, b_rsp_id, b_busy;
  logic [7:0] b_rsp_data;

  // Behavioural ALU: {carry, result}. Carry is deliberately non-zero for sub,
  // mul, and the error cases so that masking in the arbiter is visible.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] sel);
    logic [15:0] p;
    case (sel)
      3'b000: return {1'b0, a} + {1'b0, b};
      3'b001: return {(a < b), 8'(a - b)};
      3'b010: begin
        p = 16'(a) * 16'(b);
        return {|p[15:8], p[7:0]};
      end
      3'b011: return (b == 8'h00) ? 9'h1FF : {1'b0, 8'(a / b)};
      3'b100: return {1'b0, 8'(a >> b[2:0])};
      default: return {1'b1, a ^ b};
    endcase
  endfunction

  assign {a_alu_carry, a_alu_result} = alu_fn(a_alu_a, a_alu_b, a_alu_sel);
  assign {b_alu_carry, b_alu_result} = alu_fn(b_alu_a, b_alu_b, b_alu_sel);

  alu_arbiter #(.EXEC_CYCLES(A_EXEC), .RR_ENABLE(1'b1)) dut_a (
    .clk(clk), .rst(a_rst),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready),
    .req0_a(a_req0_a), .req0_b(a_req0_b), .req0_op(a_req0_op),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready),
    .req1_a(a_req1_a), .req1_b(a_req1_b), .req1_op(a_req1_op),
    .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_sel(a_alu_sel),
    .alu_result(a_alu_result), .alu_carry(a_alu_carry),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .rsp_carry(a_rsp_carry), .rsp_err(a_rsp_err), .rsp_id(a_rsp_id),
    .busy(a_busy)
  );

  alu_arbiter #(.EXEC_CYCLES(B_EXEC), .RR_ENABLE(1'b0)) dut_b (
    .clk(clk), .rst(b_rst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
    .req0_a(b_req0_a), .req0_b(b_req0_b), .req0_op(b_req0_op),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
    .req1_a(b_req1_a), .req1_b(b_req1_b), .req1_op(b_req1_op),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_sel(b_alu_sel),
    .alu_result(b_alu_result), .alu_carry(b_alu_carry),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_carry(b_rsp_carry), .rsp_err(b_rsp_err), .rsp_id(b_rsp_id),
    .busy(b_busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       err;
  } rsp_t;

  typedef struct {
    bit         port;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] data;
    logic       carry;
    logic       err;
  } vec_t;

  // Reference response from the operation rules, independent of timing.
  function automatic rsp_t exp_rsp(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op);
    rsp_t       r;
    logic [8:0] y;
    if ((op == 3'b011 && b == 8'h00) || op > 3'b100) begin
      r = '{data: 8'h00, carry: 1'b0, err: 1'b1};
    end else begin
      y = alu_fn(a, b, op);
      r = '{data: y[7:0], carry: (op == 3'b000) ? y[8] : 1'b0, err: 1'b0};
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic a_set(input int p, input logic v, input logic [7:0] av,
                       input logic [7:0] bv, input logic [2:0] op);
    if (p == 0) begin
      a_req0_valid = v; a_req0_a = av; a_req0_b = bv; a_req0_op = op;
    end else begin
      a_req1_valid = v; a_req1_a = av; a_req1_b = bv; a_req1_op = op;
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " A flags"}, {a_rsp_valid, a_rsp_carry, a_rsp_err, a_rsp_id, a_busy}, 0);
    check({tag, " A rsp_data"}, a_rsp_data, 0);
    check({tag, " A alu regs"}, {a_alu_a, a_alu_b, a_alu_sel}, 0);
    check({tag, " A readies"}, {a_req1_ready, a_req0_ready}, 0);
  endtask

  task automatic check_reset_b(input string tag);
    check({tag, " B flags"}, {b_rsp_valid, b_rsp_carry, b_rsp_err, b_rsp_id, b_busy}, 0);
    check({tag, " B rsp_data"}, b_rsp_data, 0);
    check({tag, " B alu regs"}, {b_alu_a, b_alu_b, b_alu_sel}, 0);
    check({tag, " B readies"}, {b_req1_ready, b_req0_ready}, 0);
  endtask

  // One isolated transaction on instance A with latency and payload checks.
  task automatic a_single(input string nm, input bit p, input logic [7:0] av,
                          input logic [7:0] bv, input logic [2:0] op,
                          input logic [7:0] ed, input logic ec, input logic ee);
    int   n;
    logic rdy;
    @(posedge clk); #1;
    a_rsp_ready = 1'b1;
    a_set(int'(p), 1'b1, av, bv, op);
    n = 0;
    @(negedge clk);
    rdy = p ? a_req1_ready : a_req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = p ? a_req1_ready : a_req0_ready;
    end
    check({nm, " accept"}, rdy, 1);
    @(posedge clk); #1;
    a_set(int'(p), 1'b0, 8'h00, 8'h00, 3'b000);
    n = 1;
    @(negedge clk);
    while (!a_rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, n, A_EXEC + 1);
    check({nm, " data"}, a_rsp_data, ed);
    check({nm, " carry"}, a_rsp_carry, ec);
    check({nm, " err"}, a_rsp_err, ee);
    check({nm, " id"}, a_rsp_id, p);
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, " idle after"}, {a_rsp_valid, a_busy}, 0);
  endtask

  // Random traffic on instance A against a cycle-level transaction model.
  task automatic a_random(input int cycles);
    bit         pv[2];
    logic [7:0] pa[2];
    logic [7:0] pb[2];
    logic [2:0] pop[2];
    bit         m_last   = 1'b1;
    bit         inflight = 1'b0;
    int         t        = 0;
    rsp_t       cur      = '0;
    bit         cur_id   = 1'b0;
    bit         g;
    logic [1:0] exp_rdy;
    bit         exp_v;
    int         n;
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 1) == 1) begin
          pv[p]  = 1'b1;
          pa[p]  = 8'($urandom);
          pb[p]  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
          pop[p] = 3'($urandom_range(0, 7));
        end
        a_set(p, pv[p], pa[p], pb[p], pop[p]);
      end
      a_rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (pv[0] && pv[1]) g = ~m_last;
      else                g = pv[1];
      exp_rdy = (!inflight && (pv[0] || pv[1])) ? (g ? 2'b10 : 2'b01) : 2'b00;
      exp_v   = inflight && (t >= A_EXEC + 1);
      check("rnd readies", {a_req1_ready, a_req0_ready}, exp_rdy);
      check("rnd busy", a_busy, inflight);
      check("rnd rsp_valid", a_rsp_valid, exp_v);
      if (exp_v) begin
        check("rnd rsp payload", {a_rsp_data, a_rsp_carry, a_rsp_err}, cur);
        check("rnd rsp_id", a_rsp_id, cur_id);
      end
      if (exp_rdy != 2'b00) begin
        inflight = 1'b1;
        t        = 1;
        m_last   = g;
        cur      = exp_rsp(pa[g], pb[g], pop[g]);
        cur_id   = g;
        pv[g]    = 1'b0;
      end else if (inflight) begin
        if (exp_v && a_rsp_ready) inflight = 1'b0;
        else                      t++;
      end
      @(posedge clk); #1;
    end
    a_set(0, 1'b0, 8'h00, 8'h00, 3'b000);
    a_set(1, 1'b0, 8'h00, 8'h00, 3'b000);
    a_rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while ((a_busy || a_rsp_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("rnd drain", {a_busy, a_rsp_valid}, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t       vecs[13];
    int         nr;
    int         last_c;
    int         n;
    int         starve;
    logic [7:0] ex_data[4];
    logic       ex_id[4];

    vecs[0]  = '{1'b0, 8'hF0, 8'h20, 3'b000, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h05, 8'h03, 3'b001, 8'h02, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h06, 8'h07, 3'b010, 8'h2A, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h09, 8'h00, 3'b011, 8'h00, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 8'h33, 8'h44, 3'b110, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'hC8, 8'h05, 3'b011, 8'h28, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'h10, 8'h20, 3'b001, 8'hF0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h80, 8'h03, 3'b100, 8'h10, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h10, 8'h10, 3'b010, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h12, 8'h34, 3'b111, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 8'h7F, 8'h01, 3'b101, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h30, 8'h40, 3'b000, 8'h70, 1'b0, 1'b0};

    // Both instances held in reset; A already sees two contending requests.
    a_rst = 1'b1;
    b_rst = 1'b1;
    a_set(0, 1'b1, 8'd5, 8'd3, 3'b001);
    a_set(1, 1'b1, 8'd6, 8'd7, 3'b010);
    a_rsp_ready  = 1'b1;
    b_req0_valid = 1'b0; b_req0_a = 8'h00; b_req0_b = 8'h00; b_req0_op = 3'b000;
    b_req1_valid = 1'b0; b_req1_a = 8'h00; b_req1_b = 8'h00; b_req1_op = 3'b000;
    b_rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_a("reset");
    check_reset_b("reset");

    // Contention from reset: port 0 first, then alternation every 3 cycles.
    ex_data[0] = 8'd2;  ex_id[0] = 1'b0;
    ex_data[1] = 8'd42; ex_id[1] = 1'b1;
    ex_data[2] = 8'd2;  ex_id[2] = 1'b0;
    ex_data[3] = 8'd42; ex_id[3] = 1'b1;
    @(posedge clk); #1;
    a_rst  = 1'b0;
    nr     = 0;
    last_c = 0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      @(negedge clk);
      if (a_rsp_valid) begin
        check($sformatf("contend rsp%0d id", nr), a_rsp_id, ex_id[nr]);
        check($sformatf("contend rsp%0d data", nr), a_rsp_data, ex_data[nr]);
        if (nr > 0) check($sformatf("contend rsp%0d spacing", nr), c - last_c, A_EXEC + 2);
        last_c = c;
        nr++;
      end
    end
    check("contend count", nr, 4);
    @(posedge clk); #1;
    a_set(0, 1'b0, 8'h00, 8'h00, 3'b000);
    a_set(1, 1'b0, 8'h00, 8'h00, 3'b000);
    n = 0;
    @(negedge clk);
    while (a_busy && n < 10) begin
      @(negedge clk);
      n++;
    end

    // Table of isolated operations.
    foreach (vecs[i]) begin
      a_single($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op,
               vecs[i].data, vecs[i].carry, vecs[i].err);
    end

    // Backpressure: response held 5 cycles with both ports requesting.
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    a_set(0, 1'b1, 8'h33, 8'h11, 3'b000);
    n = 0;
    @(negedge clk);
    while (!a_req0_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp accept", a_req0_ready, 1);
    @(posedge clk); #1;
    a_set(0, 1'b1, 8'h01, 8'h01, 3'b000);
    a_set(1, 1'b1, 8'h09, 8'h04, 3'b001);
    n = 0;
    @(negedge clk);
    while (!a_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("bp hold%0d rsp", k),
            {a_rsp_valid, a_rsp_data, a_rsp_carry, a_rsp_err, a_rsp_id},
            {1'b1, 8'h44, 1'b0, 1'b0, 1'b0});
      check($sformatf("bp hold%0d busy/readies", k),
            {a_busy, a_req1_ready, a_req0_ready}, 3'b100);
    end
    @(posedge clk); #1;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp handshake cycle valid", a_rsp_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp idle after", {a_busy, a_rsp_valid}, 0);
    check("bp rr grant after", {a_req1_ready, a_req0_ready}, 2'b10);
    @(posedge clk); #1;
    a_set(0, 1'b0, 8'h00, 8'h00, 3'b000);
    a_set(1, 1'b0, 8'h00, 8'h00, 3'b000);
    n = 0;
    @(negedge clk);
    while (!a_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp second rsp", {a_rsp_valid, a_rsp_data, a_rsp_id}, {1'b1, 8'h05, 1'b1});
    @(posedge clk); #1;

    // Randomised traffic from a fresh reset.
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    a_random(600);

    // Instance B: reset in the second EXEC cycle discards the operation.
    @(posedge clk); #1;
    b_rst       = 1'b0;
    b_rsp_ready = 1'b1;
    b_req0_valid = 1'b1; b_req0_a = 8'h20; b_req0_b = 8'h05; b_req0_op = 3'b010;
    n = 0;
    @(negedge clk);
    while (!b_req0_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst-exec accept", b_req0_ready, 1);
    @(posedge clk); #1;
    b_req0_valid = 1'b0;
    @(posedge clk); #1;
    b_rst = 1'b1;
    @(negedge clk);
    check("rst-exec busy before", {b_busy, b_rsp_valid}, 2'b10);
    @(posedge clk); #1;
    b_rst = 1'b0;
    @(negedge clk);
    check_reset_b("rst-exec");
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b_rsp_valid) n++;
    end
    check("rst-exec no response", n, 0);
    @(posedge clk); #1;
    b_req1_valid = 1'b1; b_req1_a = 8'h0C; b_req1_b = 8'h03; b_req1_op = 3'b011;
    n = 0;
    @(negedge clk);
    while (!b_req1_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("post-rst accept", b_req1_ready, 1);
    @(posedge clk); #1;
    b_req1_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!b_rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("post-rst latency", n, B_EXEC + 1);
    check("post-rst rsp", {b_rsp_data, b_rsp_carry, b_rsp_err, b_rsp_id},
          {8'h04, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;

    // Instance B: fixed priority with both ports valid; port 1 starves.
    b_req0_valid = 1'b1; b_req0_a = 8'h01; b_req0_b = 8'h02; b_req0_op = 3'b000;
    b_req1_valid = 1'b1; b_req1_a = 8'h03; b_req1_b = 8'h04; b_req1_op = 3'b000;
    nr     = 0;
    last_c = 0;
    starve = 0;
    for (int c = 0; c < 80 && nr < 4; c++) begin
      @(negedge clk);
      if (b_req1_ready) starve++;
      if (b_rsp_valid) begin
        check($sformatf("fixed rsp%0d", nr), {b_rsp_data, b_rsp_id}, {8'h03, 1'b0});
        if (nr > 0) check($sformatf("fixed rsp%0d spacing", nr), c - last_c, B_EXEC + 2);
        last_c = c;
        nr++;
      end
    end
    check("fixed count", nr, 4);
    check("fixed port1 never ready", starve, 0);
    @(posedge clk); #1;
    b_req0_valid = 1'b0;
    b_req1_valid = 1'b0;
    repeat (12) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
